// File: rtl/pc_issue_ctrl.sv
// Issue/hazard controller for the program counter: tracks in-flight register
// writes, stalls on read-after-write hazards and resolves branches.
module pc_issue_ctrl #(
    parameter int PC_W       = 6,
    parameter int REG_W      = 6,
    parameter int DEPTH      = 3,
    parameter int BR_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [REG_W:0]   issue_dest,
    input  logic [REG_W-1:0] src_a,
    input  logic             src_a_used,
    input  logic [REG_W-1:0] src_b,
    input  logic             src_b_used,
    input  logic             is_branch,
    input  logic [PC_W-1:0]  br_target,
    input  logic [2:0]       br_args,
    input  logic             br_resolve,
    input  logic [2:0]       comp,
    output logic             issue_accept,
    output logic             stall_override,
    output logic             take_branch,
    output logic [PC_W-1:0]  branch_loc,
    output logic             timeout_err
);
    typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} state_t;

    // Last counter value before the wait is abandoned as not taken.
    localparam logic [7:0] TIMEOUT_LAST = 8'(BR_TIMEOUT - 1);

    state_t           state_reg;
    logic [DEPTH-1:0] sb_valid_reg;
    logic [REG_W-1:0] sb_dest_reg [DEPTH];
    logic [7:0]       wait_cnt_reg;
    logic [PC_W-1:0]  pend_target_reg;
    logic [2:0]       pend_args_reg;
    logic             take_branch_reg;
    logic [PC_W-1:0]  branch_loc_reg;
    logic             timeout_err_reg;

    logic [DEPTH-1:0] match_a;
    logic [DEPTH-1:0] match_b;
    logic             hazard;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_a[gi] = sb_valid_reg[gi] && (sb_dest_reg[gi] == src_a);
            assign match_b[gi] = sb_valid_reg[gi] && (sb_dest_reg[gi] == src_b);
        end
    endgenerate

    assign hazard = issue_valid && ((src_a_used && (|match_a)) || (src_b_used && (|match_b)));

    assign issue_accept   = rst_n && (state_reg == RUN) && issue_valid && !hazard;
    assign stall_override = rst_n && ((state_reg == BR_WAIT) || hazard);
    assign take_branch    = take_branch_reg;
    assign branch_loc     = branch_loc_reg;
    assign timeout_err    = timeout_err_reg;

    // Scoreboard shifts every cycle; a non-issuing cycle inserts a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sb_dest_reg[i] <= '0;
            end
        end else begin
            sb_valid_reg[0] <= issue_accept && issue_dest[REG_W];
            sb_dest_reg[0]  <= issue_dest[REG_W-1:0];
            for (int i = 1; i < DEPTH; i++) begin
                sb_valid_reg[i] <= sb_valid_reg[i-1];
                sb_dest_reg[i]  <= sb_dest_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            pend_target_reg <= '0;
            pend_args_reg   <= '0;
            take_branch_reg <= 1'b0;
            branch_loc_reg  <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            take_branch_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (issue_accept && is_branch) begin
                        pend_target_reg <= br_target;
                        pend_args_reg   <= br_args;
                        wait_cnt_reg    <= '0;
                        state_reg       <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    // A resolve on the final wait cycle takes precedence over the timeout.
                    if (br_resolve) begin
                        state_reg <= RUN;
                        if (|(pend_args_reg & comp)) begin
                            take_branch_reg <= 1'b1;
                            branch_loc_reg  <= pend_target_reg;
                        end
                    end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_issue_ctrl.sv
// Bench for pc_issue_ctrl: directed scenarios plus random traffic checked
// against a time-based model of register busy windows and branch waits.
module tb_pc_issue_ctrl;
    localparam int PC_W = 6;
    localparam int REG_W = 6;
    localparam int DEPTH = 3;
    localparam int BR_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             issue_valid;
    logic [REG_W:0]   issue_dest;
    logic [REG_W-1:0] src_a;
    logic             src_a_used;
    logic [REG_W-1:0] src_b;
    logic             src_b_used;
    logic             is_branch;
    logic [PC_W-1:0]  br_target;
    logic [2:0]       br_args;
    logic             br_resolve;
    logic [2:0]       comp;
    logic             issue_accept;
    logic             stall_override;
    logic             take_branch;
    logic [PC_W-1:0]  branch_loc;
    logic             timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    pc_issue_ctrl #(.PC_W(PC_W), .REG_W(REG_W), .DEPTH(DEPTH), .BR_TIMEOUT(BR_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_dest(issue_dest),
        .src_a(src_a), .src_a_used(src_a_used), .src_b(src_b), .src_b_used(src_b_used),
        .is_branch(is_branch), .br_target(br_target), .br_args(br_args),
        .br_resolve(br_resolve), .comp(comp), .issue_accept(issue_accept),
        .stall_override(stall_override), .take_branch(take_branch),
        .branch_loc(branch_loc), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: a register is busy for DEPTH cycles after the cycle it issued in.
    int              cyc = 0;
    int              busy_until [1 << REG_W];
    bit              br_pend = 1'b0;
    int              br_start = 0;
    logic [PC_W-1:0] m_tgt = '0;
    logic [2:0]      m_args = '0;
    logic            m_acc = 1'b0;
    logic            m_stall = 1'b0;
    logic            m_take = 1'b0;
    logic [PC_W-1:0] m_loc = '0;
    logic            m_terr = 1'b0;

    task automatic model_comb();
        bit haz;
        if (!rst_n) begin
            m_acc = 1'b0;
            m_stall = 1'b0;
        end else if (br_pend) begin
            m_acc = 1'b0;
            m_stall = 1'b1;
        end else begin
            haz = issue_valid && ((src_a_used && busy_until[src_a] >= cyc) ||
                                  (src_b_used && busy_until[src_b] >= cyc));
            m_acc = issue_valid && !haz;
            m_stall = haz;
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            for (int r = 0; r < (1 << REG_W); r++) busy_until[r] = -1;
            br_pend = 1'b0;
            m_take = 1'b0;
            m_loc = '0;
            m_terr = 1'b0;
        end else begin
            m_take = 1'b0;
            if (br_pend) begin
                if (br_resolve) begin
                    br_pend = 1'b0;
                    if ((m_args & comp) != 3'b000) begin
                        m_take = 1'b1;
                        m_loc = m_tgt;
                    end
                end else if (cyc - br_start == BR_TIMEOUT) begin
                    br_pend = 1'b0;
                    m_terr = 1'b1;
                end
            end else if (m_acc) begin
                if (issue_dest[REG_W]) busy_until[issue_dest[REG_W-1:0]] = cyc + DEPTH;
                if (is_branch) begin
                    br_pend = 1'b1;
                    br_start = cyc;
                    m_tgt = br_target;
                    m_args = br_args;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_dest = '0;
        src_a = '0; src_a_used = 1'b0; src_b = '0; src_b_used = 1'b0;
        is_branch = 1'b0; br_target = '0; br_args = '0; br_resolve = 1'b0; comp = '0;
    endtask

    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic step();
        model_comb();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic issue_branch(input logic [PC_W-1:0] tgt, input logic [2:0] args,
                                input logic [REG_W:0] dest);
        idle_inputs();
        issue_valid = 1'b1; is_branch = 1'b1; br_target = tgt; br_args = args; issue_dest = dest;
        settle();
        n_checks++;
        if (issue_accept !== m_acc) begin
            n_errors++;
            $display("FAIL br_issue_accept got=%b exp=%b", issue_accept, m_acc);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        issue_valid = 1'b1;
        repeat (2) begin
            settle();
            n_checks++;
            if (issue_accept !== 1'b0 || stall_override !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_comb accept=%b stall=%b exp=0/0", issue_accept, stall_override);
            end
            step();
        end
        rst_n = 1'b1;
        settle();
        n_checks++;
        if (issue_accept !== m_acc || stall_override !== m_stall) begin
            n_errors++;
            $display("FAIL reset_release accept=%b stall=%b exp=%b/%b", issue_accept, stall_override, m_acc, m_stall);
        end
        n_checks++;
        if (take_branch !== 1'b0 || branch_loc !== '0 || timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_regs take=%b loc=%0d terr=%b exp=0/0/0", take_branch, branch_loc, timeout_err);
        end
        step();
        $display("reset: released, accept observed after release");
    endtask

    task automatic test_raw();
        logic [REG_W:0] dests [2];
        int stalls;
        dests[0] = 7'b1_000011;
        dests[1] = 7'b0_000011;
        for (int t = 0; t < 2; t++) begin
            idle_inputs();
            issue_valid = 1'b1; issue_dest = dests[t];
            settle();
            step();
            issue_dest = '0; src_a = 6'd3; src_a_used = 1'b1;
            stalls = 0;
            for (int k = 0; k < DEPTH + 3; k++) begin
                settle();
                n_checks++;
                if (issue_accept !== m_acc || stall_override !== m_stall) begin
                    n_errors++;
                    $display("FAIL raw_cycle k=%0d accept=%b stall=%b exp=%b/%b", k, issue_accept, stall_override, m_acc, m_stall);
                end
                if (issue_accept === 1'b1) break;
                stalls++;
                step();
            end
            n_checks++;
            if (stalls != (t == 0 ? DEPTH : 0)) begin
                n_errors++;
                $display("FAIL raw_stall_len we=%0d got=%0d exp=%0d", 1 - t, stalls, (t == 0 ? DEPTH : 0));
            end
            step();
            $display("raw: write_enable=%0d stalled %0d cycles", 1 - t, stalls);
        end
    endtask

    task automatic test_taken_branch();
        issue_branch(6'd62, 3'b100, '0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin br_resolve = 1'b1; comp = 3'b100; end
            settle();
            n_checks++;
            if (stall_override !== 1'b1 || issue_accept !== 1'b0) begin
                n_errors++;
                $display("FAIL taken_wait k=%0d stall=%b accept=%b exp=1/0", k, stall_override, issue_accept);
            end
            step();
        end
        idle_inputs();
        n_checks++;
        if (take_branch !== m_take || branch_loc !== 6'd62) begin
            n_errors++;
            $display("FAIL taken_pulse take=%b loc=%0d exp=%b/62", take_branch, branch_loc, m_take);
        end
        settle();
        n_checks++;
        if (stall_override !== m_stall) begin
            n_errors++;
            $display("FAIL taken_release stall=%b exp=%b", stall_override, m_stall);
        end
        step();
        n_checks++;
        if (take_branch !== 1'b0 || branch_loc !== 6'd62) begin
            n_errors++;
            $display("FAIL taken_one_cycle take=%b loc=%0d exp=0/62", take_branch, branch_loc);
        end
        $display("taken: branch_loc=%0d", branch_loc);
    endtask

    task automatic test_not_taken();
        logic [2:0] args_tab [2];
        logic [2:0] comp_tab [2];
        args_tab[0] = 3'b110; comp_tab[0] = 3'b001;
        args_tab[1] = 3'b000; comp_tab[1] = 3'b010;
        for (int t = 0; t < 2; t++) begin
            issue_branch(6'd17, args_tab[t], '0);
            br_resolve = 1'b1; comp = comp_tab[t];
            settle();
            step();
            idle_inputs();
            n_checks++;
            if (take_branch !== m_take || branch_loc !== m_loc) begin
                n_errors++;
                $display("FAIL not_taken args=%b take=%b loc=%0d exp=%b/%0d", args_tab[t], take_branch, branch_loc, m_take, m_loc);
            end
            settle();
            n_checks++;
            if (stall_override !== m_stall) begin
                n_errors++;
                $display("FAIL not_taken_release stall=%b exp=%b", stall_override, m_stall);
            end
            step();
            $display("not_taken: args=%b comp=%b take=%b", args_tab[t], comp_tab[t], take_branch);
        end
    endtask

    task automatic test_timeout();
        for (int mode = 0; mode < 2; mode++) begin
            if (mode == 1) begin
                idle_inputs(); rst_n = 1'b0; settle(); step(); rst_n = 1'b1;
            end
            issue_branch(6'd9, 3'b001, '0);
            for (int k = 1; k <= BR_TIMEOUT; k++) begin
                if (mode == 1 && k == BR_TIMEOUT) begin br_resolve = 1'b1; comp = 3'b010; end
                settle();
                n_checks++;
                if (stall_override !== m_stall || timeout_err !== m_terr) begin
                    n_errors++;
                    $display("FAIL timeout_wait mode=%0d k=%0d stall=%b terr=%b exp=%b/%b", mode, k, stall_override, timeout_err, m_stall, m_terr);
                end
                step();
            end
            idle_inputs();
            settle();
            n_checks++;
            if (stall_override !== 1'b0 || take_branch !== 1'b0 || timeout_err !== (mode == 0)) begin
                n_errors++;
                $display("FAIL timeout_end mode=%0d stall=%b take=%b terr=%b exp=0/0/%0d", mode, stall_override, take_branch, timeout_err, mode == 0);
            end
            step();
            $display("timeout: resolve_on_last=%0d timeout_err=%b", mode, timeout_err);
        end
    endtask

    task automatic test_reset_mid_branch();
        issue_branch(6'd3, 3'b010, '0);
        for (int k = 0; k < BR_TIMEOUT; k++) step();
        issue_branch(6'd44, 3'b111, 7'b1_000011);
        step();
        rst_n = 1'b0;
        settle();
        step();
        rst_n = 1'b1;
        issue_valid = 1'b1; src_a = 6'd3; src_a_used = 1'b1;
        settle();
        n_checks++;
        if (issue_accept !== 1'b1 || stall_override !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_comb accept=%b stall=%b exp=1/0", issue_accept, stall_override);
        end
        n_checks++;
        if (take_branch !== 1'b0 || timeout_err !== 1'b0 || branch_loc !== '0) begin
            n_errors++;
            $display("FAIL midreset_regs take=%b terr=%b loc=%0d exp=0/0/0", take_branch, timeout_err, branch_loc);
        end
        step();
        idle_inputs();
        $display("reset_mid_branch: scoreboard and branch state cleared");
    endtask

    task automatic test_random();
        logic [2:0] onehot;
        for (int n = 0; n < 800; n++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_dest = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 3))};
            src_a = 6'($urandom_range(0, 3)); src_a_used = 1'($urandom_range(0, 1));
            src_b = 6'($urandom_range(0, 3)); src_b_used = 1'($urandom_range(0, 1));
            is_branch = ($urandom_range(0, 5) == 0);
            br_target = 6'($urandom);
            br_args = 3'($urandom);
            br_resolve = ($urandom_range(0, 3) == 0);
            onehot = 3'b001 << $urandom_range(0, 2);
            comp = onehot;
            settle();
            n_checks++;
            if (issue_accept !== m_acc || stall_override !== m_stall) begin
                n_errors++;
                $display("FAIL rnd_comb cyc=%0d accept=%b stall=%b exp=%b/%b", cyc, issue_accept, stall_override, m_acc, m_stall);
            end
            step();
            n_checks++;
            if (take_branch !== m_take || branch_loc !== m_loc || timeout_err !== m_terr) begin
                n_errors++;
                $display("FAIL rnd_regs cyc=%0d take=%b loc=%0d terr=%b exp=%b/%0d/%b", cyc, take_branch, branch_loc, timeout_err, m_take, m_loc, m_terr);
            end
        end
        rst_n = 1'b1;
        idle_inputs();
        $display("random: 800 cycles of mixed traffic");
    endtask

    initial begin
        for (int r = 0; r < (1 << REG_W); r++) busy_until[r] = -1;
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_raw();
        test_taken_branch();
        test_not_taken();
        test_timeout();
        test_reset_mid_branch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
